// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity/state types and parity helpers
package uart_pkg;

  typedef enum logic [1:0] {PARITY_NONE, PARITY_ODD, PARITY_EVEN} parity_t;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // xor_all covers data bits plus the received parity bit
  function automatic logic parity_fail(parity_t mode, logic xor_all);
    case (mode)
      PARITY_EVEN: return xor_all;
      PARITY_ODD:  return ~xor_all;
      default:     return 1'b0;
    endcase
  endfunction

  // With no parity the slot is sent as an extra idle-high bit
  function automatic logic parity_bit(parity_t mode, logic xor_data);
    case (mode)
      PARITY_EVEN: return xor_data;
      PARITY_ODD:  return ~xor_data;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser with selectable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      o_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - minimal UART transmitter, one frame per accepted word
module uart_tx
  import uart_pkg::*;
#(
  parameter int      DATA_BITS    = 8,
  parameter int      STOP_BITS    = 1,
  parameter int      CLKS_PER_BIT = 1250,
  parameter parity_t PARITY       = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] i_tdata,
  input  logic                 i_tvalid,
  output logic                 o_tready,
  output logic                 o_tx
);

  localparam int FW = DATA_BITS + 2 + STOP_BITS;
  localparam int LW = $clog2(FW + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [FW-1:0] r_frame;
  logic [LW-1:0] r_left;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] w_frame;

  assign w_frame  = {{STOP_BITS{1'b1}}, parity_bit(PARITY, ^i_tdata), i_tdata, 1'b0};
  assign o_tready = (r_left == '0);
  assign o_tx     = o_tready ? 1'b1 : r_frame[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '1;
      r_left  <= '0;
      r_cnt   <= '0;
    end else if (o_tready && i_tvalid) begin
      r_frame <= w_frame;
      r_left  <= LW'(FW);
      r_cnt   <= '0;
    end else if (!o_tready) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_frame <= {1'b1, r_frame[FW-1:1]};
        r_left  <= r_left - 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - UART receiver with majority-vote sampling, parity/framing
// checks and a valid/ready output holding register with overrun detection
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int      DATA_BITS    = 8,
  parameter int      STOP_BITS    = 1,
  parameter int      CLKS_PER_BIT = 1250,
  parameter parity_t PARITY       = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_POST = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_framed: STOP_BITS must be 1..2");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
    $error("uart_rx_framed: CLKS_PER_BIT must be at least 8");
  end

  rx_state_t            r_state, w_state_n;
  logic [2:0]           r_settle;
  logic                 r_rx_prev, r_s0, r_s1, r_par, r_ferr;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx, w_fall, w_vote, w_vote_now, w_cnt_last, w_done, w_drop;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (data_in),
    .o_q   (w_rx)
  );

  // r_prev only reflects the real line three cycles after reset, so a line
  // already low at release cannot masquerade as a start edge
  assign w_fall     = r_settle[2] & r_rx_prev & ~w_rx;
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_vote_now = (r_cnt == CNT_POST);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_drop     = valid & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_done    = 1'b0;
    case (r_state)
      RX_IDLE:   if (w_fall) w_state_n = RX_START;
      RX_START:  if (w_vote_now && w_vote) w_state_n = RX_IDLE;
                 else if (w_cnt_last)      w_state_n = RX_DATA;
      RX_DATA:   if (w_cnt_last && r_idx == IDX_DATA_LAST)
                   w_state_n = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
      RX_PARITY: if (w_cnt_last) w_state_n = RX_STOP;
      RX_STOP:   if (w_vote_now && r_idx == IDX_STOP_LAST) begin
                   w_state_n = RX_IDLE;
                   w_done    = 1'b1;
                 end
      default:   w_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle  <= '0;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_settle  <= {r_settle[1:0], 1'b1};
      r_rx_prev <= w_rx;
      if (r_state == RX_IDLE || w_state_n != r_state || w_cnt_last) r_cnt <= '0;
      else                                                          r_cnt <= r_cnt + 1'b1;
      if (w_state_n != r_state) r_idx <= '0;
      else if (w_cnt_last)      r_idx <= r_idx + 1'b1;
      if (r_cnt == CNT_PRE) r_s0 <= w_rx;
      if (r_cnt == CNT_MID) r_s1 <= w_rx;
      if (r_state == RX_START) begin
        r_par  <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_vote_now) begin
        case (r_state)
          RX_DATA: begin
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ w_vote;
          end
          RX_PARITY: r_par <= r_par ^ w_vote;
          RX_STOP:   if (!w_vote) r_ferr <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  // A frame finishing on a handshake cycle replaces the word without a gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= w_done & w_drop;
      if (w_done && !w_drop) begin
        valid      <= 1'b1;
        data_out   <= r_shift;
        parity_err <= parity_fail(PARITY, r_par);
        frame_err  <= r_ferr | ~w_vote;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed table-driven bench for uart_rx_framed
`timescale 1ns/1ps
module tb_uart_rx_framed;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic       e;
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic [7:0] xd;
    logic       xpe;
    logic       xfe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, line_a, line_e, ready_a, use_tx, tx_valid, tx_ready, tx_line, rx_in_a;
  logic [7:0] tx_data, dout_a, dout_e;
  logic       valid_a, perr_a, ferr_a, ovr_a, valid_e, perr_e, ferr_e, ovr_e;

  assign rx_in_a = use_tx ? tx_line : line_a;

  uart_rx_framed #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .PARITY(PARITY_NONE)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(rx_in_a), .data_out(dout_a), .valid(valid_a),
    .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a));

  uart_rx_framed #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .PARITY(PARITY_EVEN)) dut_e (
    .clk(clk), .rst_n(rst_n), .data_in(line_e), .data_out(dout_e), .valid(valid_e),
    .ready(1'b1), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .PARITY(PARITY_NONE)) u_tx (
    .clk(clk), .rst_n(rst_n), .i_tdata(tx_data), .i_tvalid(tx_valid),
    .o_tready(tx_ready), .o_tx(tx_line));

  rx_t q_a[$], q_e[$];
  int  vcyc_a = 0, vcyc_e = 0, ocyc_a = 0;
  int  n_cmp = 0, n_bad = 0;
  vec_t tbl[9];

  initial forever begin
    @(negedge clk);
    #1;
    if (valid_a) vcyc_a++;
    if (valid_e) vcyc_e++;
    if (ovr_a)   ocyc_a++;
    if (valid_a && ready_a) q_a.push_back('{d: dout_a, pe: perr_a, fe: ferr_a});
    if (valid_e)            q_e.push_back('{d: dout_e, pe: perr_e, fe: ferr_e});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic drive_bit(input logic to_e, input logic v);
    if (to_e) line_e = v;
    else      line_a = v;
    hold_bits(1);
  endtask

  task automatic send_frame(input logic to_e, input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(to_e, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_e, d[i]);
    if (to_e) drive_bit(to_e, pbit);
    drive_bit(to_e, stop);
    if (to_e) line_e = 1'b1;
    else      line_a = 1'b1;
  endtask

  task automatic wait_frame(input logic to_e, input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = to_e ? (q_e.size() != 0) : (q_a.size() != 0);
    end
  endtask

  task automatic expect_frame(input string name, input logic to_e, input logic [7:0] xd,
                              input logic xpe, input logic xfe);
    logic got;
    rx_t  r;
    wait_frame(to_e, 4 * CPB, got);
    check({name, "_got"}, got, 1'b1);
    if (got) begin
      r = to_e ? q_e.pop_front() : q_a.pop_front();
      check({name, "_data"}, r.d, xd);
      check({name, "_perr"}, r.pe, xpe);
      check({name, "_ferr"}, r.fe, xfe);
    end
  endtask

  initial begin
    int   v0, o0;
    logic got;
    logic [7:0] b;
    rx_t  r;

    tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; line_a = 1'b1; line_e = 1'b1; ready_a = 1'b1;
    use_tx = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_a, 1'b0);
    check("rst_data", dout_a, 8'h00);
    check("rst_flags", {perr_a, ferr_a, ovr_a}, 3'b000);
    check("rst_valid_e", valid_e, 1'b0);
    rst_n = 1'b1;
    hold_bits(1);

    for (int i = 0; i < 9; i++) begin
      v0 = tbl[i].e ? vcyc_e : vcyc_a;
      send_frame(tbl[i].e, tbl[i].d, tbl[i].pbit, tbl[i].stop);
      hold_bits(1);
      expect_frame($sformatf("vec%0d", i), tbl[i].e, tbl[i].xd, tbl[i].xpe, tbl[i].xfe);
      check($sformatf("vec%0d_valid_cycles", i), (tbl[i].e ? vcyc_e : vcyc_a) - v0, 1);
    end

    v0 = vcyc_a;
    line_a = 1'b0;
    repeat (4) @(negedge clk);
    line_a = 1'b1;
    hold_bits(2);
    check("glitch_no_valid", vcyc_a - v0, 0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    hold_bits(1);
    expect_frame("after_glitch", 1'b0, 8'h81, 1'b0, 1'b0);

    ready_a = 1'b0;
    o0 = ocyc_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    hold_bits(1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    hold_bits(1);
    check("ovr_valid_held", valid_a, 1'b1);
    check("ovr_data_held", dout_a, 8'h11);
    check("ovr_pulses", ocyc_a - o0, 1);
    ready_a = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_q_size", q_a.size(), 1);
    if (q_a.size() != 0) begin
      r = q_a.pop_front();
      check("ovr_popped", r.d, 8'h11);
    end
    check("ovr_valid_drop", valid_a, 1'b0);

    v0 = vcyc_a;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    rst_n = 1'b0;
    line_a = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_valid", valid_a, 1'b0);
    rst_n = 1'b1;
    hold_bits(3);
    line_a = 1'b1;
    hold_bits(3);
    check("midrst_no_frame", (vcyc_a - v0) + q_a.size(), 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    hold_bits(1);
    expect_frame("after_rst", 1'b0, 8'h5A, 1'b0, 1'b0);

    use_tx = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      got = 1'b0;
      for (int k = 0; k < 40 * CPB && !got; k++) begin
        if (tx_ready) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) check($sformatf("lb%0d_tx_ready", i), got, 1'b1);
      tx_data = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_frame(1'b0, 14 * CPB, got);
      if (!got) begin
        check($sformatf("lb%0d_got", i), got, 1'b1);
      end else begin
        r = q_a.pop_front();
        check($sformatf("lb%0d", i), {r.pe, r.fe, r.d}, {2'b00, b});
      end
    end
    hold_bits(3);
    use_tx = 1'b0;

    ready_a = 1'b0;
    send_frame(1'b0, 8'h96, 1'b0, 1'b1);
    hold_bits(1);
    check("async_pre_valid", {valid_a, dout_a}, {1'b1, 8'h96});
    rst_n = 1'b0;
    #2;
    check("async_rst_out", {valid_a, dout_a}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame, range 1..2.
REQ-003 Parameter CLKS_PER_BIT, default 1250: clk cycles per bit, minimum 8.
REQ-004 Parameter PARITY, default PARITY_NONE: parity mode, one of PARITY_NONE, PARITY_ODD or PARITY_EVEN.
REQ-005 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port data_in, input, 1: serial line, asynchronous to clk; idles high.
REQ-008 Port data_out, output, DATA_BITS: received word, LSB first on the line.
REQ-009 Port valid, output, 1: data_out, parity_err and frame_err are held and valid.
REQ-010 Port ready, input, 1: consumer accepts the word when valid && ready.
REQ-011 Port parity_err, output, 1: held word failed its parity check; always 0 when PARITY_NONE.
REQ-012 Port frame_err, output, 1: held word had at least one stop bit sampled low.
REQ-013 Port overrun, output, 1: one-cycle pulse when a completed frame was dropped.

Function
REQ-014 data_in SHALL pass through a 2-flop synchroniser; all further logic SHALL use the synchronised signal.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START SHALL occur on a high-to-low transition of the synchronised line.
REQ-017 Each bit SHALL be decided by a 3-sample majority vote on the cycles mid-1, mid and mid+1, where mid = CLKS_PER_BIT/2 cycles after bit start.
REQ-018 START SHALL return to IDLE with no output when the start-bit vote is 1 (glitch rejection); otherwise it SHALL enter DATA.
REQ-019 DATA SHALL shift DATA_BITS votes LSB-first at CLKS_PER_BIT intervals, then enter PARITY when PARITY != PARITY_NONE, else STOP.
REQ-020 PARITY SHALL compute parity_err as follows: for even parity, XOR(data bits, parity bit) != 0; for odd parity, XOR(data bits, parity bit) != 1.
REQ-021 STOP SHALL vote STOP_BITS bits; any vote of 0 SHALL set frame_err for that frame.
REQ-022 After the last stop-bit vote the FSM SHALL return to IDLE immediately, so that the next start edge is accepted within half a bit.
REQ-023 A completed frame SHALL load the output register, and valid SHALL rise on the cycle after the last stop-bit vote; frames with errors SHALL still be delivered, with their flags set.
REQ-024 valid SHALL remain high with data_out and flags stable until a valid && ready cycle, then fall on the next cycle unless a frame completes in that same cycle.
REQ-025 If a frame completes while valid && !ready, the new frame SHALL be discarded, the held word kept, and overrun pulsed for one cycle.
REQ-026 If a frame completes in the same cycle as the handshake, the new frame SHALL load and valid SHALL stay high with no overrun.
REQ-027 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and the bit index $clog2(DATA_BITS+1) bits wide; there SHALL be no wrap-around within a frame.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counters 0, synchroniser flops 1, valid 0, data_out 0, parity_err 0, frame_err 0 and overrun 0.
REQ-029 Reset mid-frame SHALL abandon the partial frame, and no output SHALL result from it.
REQ-030 After reset release the receiver SHALL wait for a fresh falling edge, ignoring a line already low at release until it has been high.

Structure
REQ-031 Package uart_pkg SHALL hold the parity_t enum (PARITY_NONE, PARITY_ODD, PARITY_EVEN) and the rx_state_t enum; uart_tx reuses parity_t.
REQ-032 Sub-module sync_2ff (1-bit, reset value parameterised) SHALL implement the synchroniser.
REQ-033 Parameter legality SHALL be checked by elaboration-time assertions.

Verification (DATA_BITS=8, CLKS_PER_BIT=16 unless stated)
REQ-034 Frame 0xA5 in 8N1 with ready=1 -> data_out=0xA5, valid for exactly 1 cycle, parity_err=0, frame_err=0.
REQ-035 With PARITY_EVEN, frame 0x03 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
REQ-036 Frame 0x3C with stop bit driven 0 -> data_out=0x3C, frame_err=1; the next 0x5A frame is received cleanly.
REQ-037 data_in low for 4 cycles then high -> no valid and FSM back in IDLE; the next 0x81 frame is received correctly.
REQ-038 With ready=0, frames 0x11 then 0x22 -> data_out stays 0x11 and overrun pulses once at the end of 0x22.
REQ-039 rst_n asserted during DATA of 0xFF -> valid=0; after release, 0x5A is received; then 100 random bytes looped back from uart_tx, matched with no errors.
